addsub_pipelined_ripple: RTL and testbench

- Pipelined successor to the single-cycle no-carry adder/subtractor in the ALU.
- Computes (+/-A) + (+/-B) over a WORD_WIDTH word split into PIPE_STAGES ripple-carry chunks, with one chunk added per clock stage.
- Operand skew and result deskew registers align the chunks.
- Produces sum, carry_out and signed overflow, plus zero and negative predicates for later comparisons, with a valid flag and a global stall enable.

---
 rtl/addsub_pipelined_ripple_pkg.sv | 25 ++
 rtl/addsub_chunk_stage.sv | 43 ++++
 rtl/addsub_pipelined_ripple.sv | 146 ++++++++++++++
 tb/tb_addsub_pipelined_ripple.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/addsub_pipelined_ripple_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pipelined_ripple_pkg
// Description : Shared constants and helpers for the chunked add/sub pipeline.
// Revision    : 1.0
// ============================================================================

// Rejects word/stage geometries that cannot be split into equal chunks.
`define ADDSUB_CHECK_DIVISIBLE(W, P) \
    if (((P) < 1) || (((W) % (P)) != 0)) begin : g_bad_geometry \
        $error("addsub: WORD_WIDTH must be divisible by PIPE_STAGES (>=1)"); \
    end

package addsub_pipelined_ripple_pkg;

    // A chunk sum plus up to two injected +1s never exceeds 2, so two bits suffice.
    localparam int CARRY_WIDTH = 2;

    function automatic int chunk_width(input int word_width, input int pipe_stages);
        return (pipe_stages > 0) ? (word_width / pipe_stages) : word_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/addsub_chunk_stage.sv
`default_nettype none
// ============================================================================
// Module      : addsub_chunk_stage
// Description : One registered CHUNK_WIDTH+2 ripple adder with 2-bit carry.
// Revision    : 1.0
// ============================================================================
module addsub_chunk_stage
    import addsub_pipelined_ripple_pkg::*;
#(
    parameter int CHUNK_WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic [CHUNK_WIDTH-1:0] i_a,
    input  logic [CHUNK_WIDTH-1:0] i_b,
    input  logic [CARRY_WIDTH-1:0] i_cin,
    output logic [CHUNK_WIDTH-1:0] o_sum,
    output logic [CARRY_WIDTH-1:0] o_carry
);

    logic [CHUNK_WIDTH+1:0] w_full;
    logic [CHUNK_WIDTH-1:0] r_sum;
    logic [CARRY_WIDTH-1:0] r_carry;

    assign w_full = {2'b00, i_a} + {2'b00, i_b} + {{CHUNK_WIDTH{1'b0}}, i_cin};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum   <= '0;
            r_carry <= '0;
        end else if (i_en) begin
            r_sum   <= w_full[CHUNK_WIDTH-1:0];
            r_carry <= w_full[CHUNK_WIDTH+1:CHUNK_WIDTH];
        end
    end

    assign o_sum   = r_sum;
    assign o_carry = r_carry;

endmodule

`default_nettype wire

// File: rtl/addsub_pipelined_ripple.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pipelined_ripple
// Description : (+/-A)+(+/-B) as PIPE_STAGES skewed ripple chunks with flags.
// Revision    : 1.0
// ============================================================================
module addsub_pipelined_ripple
    import addsub_pipelined_ripple_pkg::*;
#(
    parameter int WORD_WIDTH  = 36,
    parameter int PIPE_STAGES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] A,
    input  logic                  A_negative,
    input  logic [WORD_WIDTH-1:0] B,
    input  logic                  B_negative,
    output logic                  out_valid,
    output logic [WORD_WIDTH-1:0] sum,
    output logic                  carry_out,
    output logic                  overflow,
    output logic                  zero,
    output logic                  negative
);

    localparam int c_CHUNK_WIDTH = chunk_width(WORD_WIDTH, PIPE_STAGES);

    `ADDSUB_CHECK_DIVISIBLE(WORD_WIDTH, PIPE_STAGES)

    logic [WORD_WIDTH-1:0]    w_a_s;
    logic [WORD_WIDTH-1:0]    w_b_s;
    logic [CARRY_WIDTH-1:0]   w_cin0;
    logic [c_CHUNK_WIDTH-1:0] w_op_a      [PIPE_STAGES];
    logic [c_CHUNK_WIDTH-1:0] w_op_b      [PIPE_STAGES];
    logic [c_CHUNK_WIDTH-1:0] w_stage_sum [PIPE_STAGES];
    logic [CARRY_WIDTH-1:0]   w_carry     [PIPE_STAGES];
    logic [WORD_WIDTH-1:0]    w_sum_aligned;
    logic [PIPE_STAGES-1:0]   r_valid;
    logic                     r_ab_msb;
    logic                     w_cout;

    assign w_a_s  = A_negative ? ~A : A;
    assign w_b_s  = B_negative ? ~B : B;
    assign w_cin0 = {1'b0, A_negative} + {1'b0, B_negative};

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_chunk
        localparam int c_DESKEW = PIPE_STAGES - 1 - k;
        logic [CARRY_WIDTH-1:0] w_cin;

        // Chunk k waits k stages so its carry-in from chunk k-1 is ready.
        if (k == 0) begin : g_no_skew
            assign w_op_a[k] = w_a_s[c_CHUNK_WIDTH-1:0];
            assign w_op_b[k] = w_b_s[c_CHUNK_WIDTH-1:0];
            assign w_cin     = w_cin0;
        end else begin : g_skew
            logic [c_CHUNK_WIDTH-1:0] r_skew_a [k];
            logic [c_CHUNK_WIDTH-1:0] r_skew_b [k];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < k; i++) begin
                        r_skew_a[i] <= '0;
                        r_skew_b[i] <= '0;
                    end
                end else if (enable) begin
                    r_skew_a[0] <= w_a_s[k*c_CHUNK_WIDTH +: c_CHUNK_WIDTH];
                    r_skew_b[0] <= w_b_s[k*c_CHUNK_WIDTH +: c_CHUNK_WIDTH];
                    for (int i = 1; i < k; i++) begin
                        r_skew_a[i] <= r_skew_a[i-1];
                        r_skew_b[i] <= r_skew_b[i-1];
                    end
                end
            end

            assign w_op_a[k] = r_skew_a[k-1];
            assign w_op_b[k] = r_skew_b[k-1];
            assign w_cin     = w_carry[k-1];
        end

        addsub_chunk_stage #(
            .CHUNK_WIDTH (c_CHUNK_WIDTH)
        ) u_stage (
            .clk     (clock),
            .rst     (reset),
            .i_en    (enable),
            .i_a     (w_op_a[k]),
            .i_b     (w_op_b[k]),
            .i_cin   (w_cin),
            .o_sum   (w_stage_sum[k]),
            .o_carry (w_carry[k])
        );

        // Early chunks wait until the top chunk completes.
        if (c_DESKEW == 0) begin : g_no_deskew
            assign w_sum_aligned[k*c_CHUNK_WIDTH +: c_CHUNK_WIDTH] = w_stage_sum[k];
        end else begin : g_deskew
            logic [c_CHUNK_WIDTH-1:0] r_deskew [c_DESKEW];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < c_DESKEW; i++) begin
                        r_deskew[i] <= '0;
                    end
                end else if (enable) begin
                    r_deskew[0] <= w_stage_sum[k];
                    for (int i = 1; i < c_DESKEW; i++) begin
                        r_deskew[i] <= r_deskew[i-1];
                    end
                end
            end

            assign w_sum_aligned[k*c_CHUNK_WIDTH +: c_CHUNK_WIDTH] = r_deskew[c_DESKEW-1];
        end
    end

    // Operand sign bits are captured alongside the top chunk's add.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid  <= '0;
            r_ab_msb <= 1'b0;
        end else if (enable) begin
            r_valid[0] <= in_valid;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
            r_ab_msb <= w_op_a[PIPE_STAGES-1][c_CHUNK_WIDTH-1]
                      ^ w_op_b[PIPE_STAGES-1][c_CHUNK_WIDTH-1];
        end
    end

    assign w_cout = w_carry[PIPE_STAGES-1][0];

    // Result fields read as zero whenever the output slot is not valid.
    assign out_valid = r_valid[PIPE_STAGES-1];
    assign sum       = out_valid ? w_sum_aligned : '0;
    assign carry_out = out_valid & w_cout;
    assign overflow  = out_valid & (r_ab_msb ^ w_sum_aligned[WORD_WIDTH-1] ^ w_cout);
    assign zero      = out_valid & (w_sum_aligned == '0);
    assign negative  = out_valid & w_sum_aligned[WORD_WIDTH-1];

endmodule

`default_nettype wire

// File: tb/tb_addsub_pipelined_ripple.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_pipelined_ripple
// Description : Directed and swept checks of the chunked add/sub pipeline.
// Revision    : 1.0
// ============================================================================
module tb_addsub_pipelined_ripple;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable, in_valid, A_negative, B_negative;
    logic [7:0] A, B;
    logic       m_ov, m_c, m_o, m_z, m_n;
    logic [7:0] m_s;

    logic       sw_en, sw_v, sw_an, sw_bn;
    logic [7:0] sw_a, sw_b;
    logic       p1_ov, p1_c, p1_o, p1_z, p1_n;
    logic       p8_ov, p8_c, p8_o, p8_z, p8_n;
    logic [7:0] p1_s, p8_s;

    logic [12:0] w_obs, w_obs1, w_obs8;
    logic [12:0] exp_hist [256];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    addsub_pipelined_ripple #(.WORD_WIDTH(8), .PIPE_STAGES(4)) u_dut (
        .clock(clock), .reset(reset), .enable(enable), .in_valid(in_valid),
        .A(A), .A_negative(A_negative), .B(B), .B_negative(B_negative),
        .out_valid(m_ov), .sum(m_s), .carry_out(m_c), .overflow(m_o),
        .zero(m_z), .negative(m_n));

    addsub_pipelined_ripple #(.WORD_WIDTH(8), .PIPE_STAGES(1)) u_p1 (
        .clock(clock), .reset(reset), .enable(sw_en), .in_valid(sw_v),
        .A(sw_a), .A_negative(sw_an), .B(sw_b), .B_negative(sw_bn),
        .out_valid(p1_ov), .sum(p1_s), .carry_out(p1_c), .overflow(p1_o),
        .zero(p1_z), .negative(p1_n));

    addsub_pipelined_ripple #(.WORD_WIDTH(8), .PIPE_STAGES(8)) u_p8 (
        .clock(clock), .reset(reset), .enable(sw_en), .in_valid(sw_v),
        .A(sw_a), .A_negative(sw_an), .B(sw_b), .B_negative(sw_bn),
        .out_valid(p8_ov), .sum(p8_s), .carry_out(p8_c), .overflow(p8_o),
        .zero(p8_z), .negative(p8_n));

    // Packed as {valid, sum, carry_out, overflow, zero, negative}.
    assign w_obs  = {m_ov, m_s, m_c, m_o, m_z, m_n};
    assign w_obs1 = {p1_ov, p1_s, p1_c, p1_o, p1_z, p1_n};
    assign w_obs8 = {p8_ov, p8_s, p8_c, p8_o, p8_z, p8_n};

    function automatic logic [12:0] model(input logic [7:0] a, input logic an,
                                          input logic [7:0] b, input logic bn);
        logic [7:0] as_v, bs_v;
        logic [9:0] ex;
        as_v = an ? ~a : a;
        bs_v = bn ? ~b : b;
        ex   = {2'b00, as_v} + {2'b00, bs_v} + {9'd0, an} + {9'd0, bn};
        return {1'b1, ex[7:0], ex[8], as_v[7] ^ bs_v[7] ^ ex[7] ^ ex[8],
                ex[7:0] == 8'h00, ex[7]};
    endfunction

    // full=0 compares only the valid bit (payload is don't-care on bubbles).
    task automatic check(input string tag, input logic [12:0] obs,
                         input logic [12:0] exp, input bit full);
        logic [12:0] msk;
        msk = full ? 13'h1FFF : 13'h1000;
        n_checks++;
        assert ((obs & msk) === (exp & msk)) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (mask %h)", tag, obs, exp, msk);
        end
    endtask

    task automatic cyc(input logic en, input logic v, input logic [7:0] a,
                       input logic an, input logic [7:0] b, input logic bn);
        enable = en; in_valid = v; A = a; A_negative = an; B = b; B_negative = bn;
        @(posedge clock);
        #1;
    endtask

    task automatic single(input string tag, input logic [7:0] a, input logic an,
                          input logic [7:0] b, input logic bn, input logic [12:0] exp);
        cyc(1'b1, 1'b1, a, an, b, bn);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        check({tag, "_early"}, w_obs, 13'h0000, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        check(tag, w_obs, exp, 1'b1);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; in_valid = 1'b0;
        A = '0; B = '0; A_negative = 1'b0; B_negative = 1'b0;
        sw_en = 1'b1; sw_v = 1'b0; sw_a = '0; sw_b = '0; sw_an = 1'b0; sw_bn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", w_obs, 13'h0000, 1'b1);
        reset = 1'b0;

        single("t1_5p3",     8'h05, 1'b0, 8'h03, 1'b0, {1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0});
        single("t2_7Fp1",    8'h7F, 1'b0, 8'h01, 1'b0, {1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1});
        single("t3_m3p3",    8'h03, 1'b1, 8'h03, 1'b0, {1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
        single("t4_m0m0",    8'h00, 1'b1, 8'h00, 1'b1, {1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
        single("t4b_mFFmFF", 8'hFF, 1'b1, 8'hFF, 1'b1, {1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0});

        // Stream with stalls; junk presented during stalls must be ignored.
        cyc(1'b1, 1'b1, 8'h01, 1'b0, 8'h01, 1'b0);
        cyc(1'b1, 1'b1, 8'h02, 1'b0, 8'h02, 1'b0);
        cyc(1'b0, 1'b1, 8'hAA, 1'b0, 8'hAA, 1'b0);
        check("t5_stall_novalid", w_obs, 13'h0000, 1'b0);
        cyc(1'b1, 1'b1, 8'h40, 1'b0, 8'h40, 1'b0);
        cyc(1'b1, 1'b1, 8'hFF, 1'b0, 8'h01, 1'b0);
        check("t5_r1", w_obs, {1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
        cyc(1'b0, 1'b1, 8'h33, 1'b1, 8'h33, 1'b0);
        check("t5_r1_frozen", w_obs, {1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        check("t5_r2", w_obs, {1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        check("t5_r3", w_obs, {1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1}, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        check("t5_r4", w_obs, {1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0}, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        check("t5_bubble", w_obs, 13'h0000, 1'b0);

        // Reset with one result at the output and three in flight.
        cyc(1'b1, 1'b1, 8'h01, 1'b0, 8'h01, 1'b0);
        cyc(1'b1, 1'b1, 8'h02, 1'b0, 8'h02, 1'b0);
        cyc(1'b1, 1'b1, 8'h03, 1'b0, 8'h03, 1'b0);
        cyc(1'b1, 1'b1, 8'h04, 1'b0, 8'h04, 1'b0);
        check("t6_pre", w_obs, {1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_clear", w_obs, 13'h0000, 1'b1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 8'h55, 1'b0, 8'h11, 1'b0);
            check("t6_no_stale", w_obs, 13'h0000, 1'b0);
        end
        single("t6_fresh", 8'h05, 1'b0, 8'h05, 1'b0, {1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0});

        // Random sweep against the unpipelined equation for 1 and 8 stages.
        enable = 1'b0;
        for (int c = 0; c < 200; c++) begin
            sw_v  = ($urandom_range(0, 3) != 0);
            sw_a  = 8'($urandom);
            sw_b  = 8'($urandom);
            sw_an = 1'($urandom);
            sw_bn = 1'($urandom);
            exp_hist[c] = sw_v ? model(sw_a, sw_an, sw_b, sw_bn) : 13'h0000;
            @(posedge clock);
            #1;
            check("sweep_p1", w_obs1, exp_hist[c], exp_hist[c][12]);
            if (c >= 7) begin
                check("sweep_p8", w_obs8, exp_hist[c-7], exp_hist[c-7][12]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
